// File: rtl/toggle_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : toggle_bank_sequencer
// Brief    : Sequences a bank of T-type bits: clear, or toggle a masked subset
//            once per clock for a commanded number of cycles.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_clear,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_next;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_q         <= '0;
            r_mask      <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_next_state;
            r_q         <= w_q_next;
            r_mask      <= w_mask_next;
            r_remaining <= w_remaining_next;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_q_next         = r_q;
        w_mask_next      = r_mask;
        w_remaining_next = r_remaining;

        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Clear wins over toggling; mask and count are don't-care.
                    if (cmd_clear) begin
                        w_q_next     = '0;
                        w_next_state = ST_DONE;
                    end else if (cmd_count == c_cnt_zero) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_mask_next      = cmd_mask;
                        w_remaining_next = cmd_count;
                        w_next_state     = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    w_remaining_next = c_cnt_zero;
                    w_next_state     = ST_DONE;
                end else if (!pause) begin
                    w_q_next = r_q ^ r_mask;
                    // Saturate at zero so a stray extra cycle can never wrap.
                    if (r_remaining != c_cnt_zero) begin
                        w_remaining_next = r_remaining - c_cnt_one;
                    end
                    if (r_remaining <= c_cnt_one) begin
                        w_next_state = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign q         = r_q;
    assign remaining = r_remaining;

endmodule
`default_nettype wire
